// File: rtl/iic_slave.sv
// iic_slave -- I2C target (responder) for an open-drain bus.
//
// Oversamples SCL/SDA with clk through a 2-flop synchroniser and a FILT_CYC
// glitch filter. It decodes START, repeated START and STOP, matches a 7-bit
// address, and then either delivers written bytes (rx_*) or serialises
// user-supplied bytes (tx_*) onto SDA for master reads.
//
// Optional feature macro: SCL_STRETCH_EN
//   When defined, SCL is held low after a write ACK while rx_ready=0, and
//   before the first bit of a read byte while tx_valid=0.
//   When undefined, scl_oen_n stays 1 and rx_ready/tx_valid are ignored.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   scl_i, sda_i          pad inputs
//   scl_o/sda_o           constant 0 (open drain)
//   scl_oen_n/sda_oen_n   active-low output enables (0 pulls the line low)
//   rx_data/rx_valid      last written byte + 1-cycle strobe; rx_ready for stretching
//   tx_data/tx_valid      next read byte; tx_req is a 1-cycle request pulse
//   busy                  START seen and no STOP yet
//   addressed, rw         address ACKed for this transfer, R/W bit (1 = read)
module iic_slave #(
  parameter logic [6:0] SLAVE_ADR = 7'h50,
  parameter int         FILT_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       scl_oen_n,
  output logic       sda_o,
  output logic       sda_oen_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic       addressed,
  output logic       rw
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;

  localparam logic [2:0] FCNT = 3'(FILT_CYC - 1);

  state_t     state;
  logic [1:0] scl_sync, sda_sync;
  logic [2:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;     // bits received so far in the current byte
  logic [6:0] txsh;      // remaining read bits, next one at [6]
  logic       ld_pend;   // read byte load waiting on tx_valid
  logic       wr_hold;   // SCL held after a write ACK waiting on rx_ready
  logic       tx_ok, rx_ok;

  assign scl_o = 1'b0;
  assign sda_o = 1'b0;

`ifdef SCL_STRETCH_EN
  assign tx_ok = tx_valid;
  assign rx_ok = rx_ready;
`else
  // Handshakes are ignored: bytes are always taken/offered immediately.
  assign tx_ok = 1'b1;
  assign rx_ok = 1'b1;
  logic unused_hs;
  assign unused_hs = rx_ready ^ tx_valid;
`endif

  // Synchroniser + glitch filter: a new level must be seen FILT_CYC samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_f;
      sda_d    <= sda_f;
      if (scl_sync[1] == scl_f) scl_cnt <= '0;
      else if (scl_cnt == FCNT) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 3'd1;
      if (sda_sync[1] == sda_f) sda_cnt <= '0;
      else if (sda_cnt == FCNT) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 3'd1;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  // Protocol FSM. Each *_ACK state is entered with bit_cnt=8: the first SCL
  // fall there opens the 9th clock, the 9th rise clears bit_cnt, and the
  // following fall (bit_cnt=0) closes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scl_oen_n <= 1'b1;
      sda_oen_n <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
      addressed <= 1'b0;
      rw        <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      txsh      <= '0;
      ld_pend   <= 1'b0;
      wr_hold   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_det || start_det) begin
        state     <= stop_det ? IDLE : ADDR;
        busy      <= start_det;
        addressed <= 1'b0;
        sda_oen_n <= 1'b1;
        scl_oen_n <= 1'b1;
        bit_cnt   <= '0;
        ld_pend   <= 1'b0;
        wr_hold   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            shreg <= {shreg[5:0], sda_f};
            if (bit_cnt == 4'd7) begin
              if (shreg == SLAVE_ADR) begin
                state   <= ADDR_ACK;
                rw      <= sda_f;
                bit_cnt <= 4'd8;
              end else begin
                state   <= IDLE;
                bit_cnt <= '0;
              end
            end else bit_cnt <= bit_cnt + 4'd1;
          end
          ADDR_ACK: if (scl_fall) begin
            if (bit_cnt == 4'd8) sda_oen_n <= 1'b0;
            else if (rw) begin
              state <= RD_DATA;
              if (tx_ok) begin
                txsh      <= tx_data[6:0];
                sda_oen_n <= tx_data[7];
              end else begin
                ld_pend   <= 1'b1;
                scl_oen_n <= 1'b0;
                sda_oen_n <= 1'b1;
              end
            end else begin
              state     <= WR_DATA;
              sda_oen_n <= 1'b1;
            end
          end else if (scl_rise) begin
            bit_cnt   <= '0;
            addressed <= 1'b1;
            tx_req    <= rw;
          end
          WR_DATA: if (wr_hold) begin
            if (rx_ok) begin
              scl_oen_n <= 1'b1;
              wr_hold   <= 1'b0;
            end
          end else if (scl_rise) begin
            shreg <= {shreg[5:0], sda_f};
            if (bit_cnt == 4'd7) begin
              rx_data  <= {shreg, sda_f};
              rx_valid <= 1'b1;
              state    <= WR_ACK;
              bit_cnt  <= 4'd8;
            end else bit_cnt <= bit_cnt + 4'd1;
          end
          WR_ACK: if (scl_fall) begin
            if (bit_cnt == 4'd8) sda_oen_n <= 1'b0;
            else begin
              sda_oen_n <= 1'b1;
              state     <= WR_DATA;
              if (!rx_ok) begin
                scl_oen_n <= 1'b0;
                wr_hold   <= 1'b1;
              end
            end
          end else if (scl_rise) bit_cnt <= '0;
          RD_DATA: if (ld_pend) begin
            if (tx_ok) begin
              txsh      <= tx_data[6:0];
              sda_oen_n <= tx_data[7];
              scl_oen_n <= 1'b1;
              ld_pend   <= 1'b0;
            end
          end else if (scl_rise) begin
            if (bit_cnt == 4'd7) begin
              state   <= RD_ACK;
              bit_cnt <= 4'd8;
            end else bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            sda_oen_n <= txsh[6];
            txsh      <= {txsh[5:0], 1'b0};
          end
          RD_ACK: if (scl_fall) begin
            if (bit_cnt == 4'd8) sda_oen_n <= 1'b1;
            else begin
              state <= RD_DATA;
              if (tx_ok) begin
                txsh      <= tx_data[6:0];
                sda_oen_n <= tx_data[7];
              end else begin
                ld_pend   <= 1'b1;
                scl_oen_n <= 1'b0;
              end
            end
          end else if (scl_rise) begin
            bit_cnt <= '0;
            if (sda_f) begin
              state     <= IDLE;
              addressed <= 1'b0;
            end else tx_req <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_slave.sv
// Self-checking bench for iic_slave: a bit-banged I2C master drives the
// bus (wired-AND with the target's enables); a transaction-level model
// predicts ACKs, received bytes, read data and request counts.
module tb_iic_slave;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0, rst = 1'b1;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  logic       scl_line, sda_line;
  logic       scl_o, scl_oen_n, sda_o, sda_oen_n;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_req, busy, addressed, rw;

  int passed = 0, total = 0, fails = 0;
  int rx_cnt = 0, tx_cnt = 0, hold_cnt = 0;
  logic [7:0] rxq[$];

  assign scl_line = m_scl & (scl_oen_n | scl_o);
  assign sda_line = m_sda & (sda_oen_n | sda_o);

  iic_slave dut (
    .clk(clk), .rst(rst), .scl_i(scl_line), .sda_i(sda_line),
    .scl_o(scl_o), .scl_oen_n(scl_oen_n), .sda_o(sda_o), .sda_oen_n(sda_oen_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_req(tx_req),
    .busy(busy), .addressed(addressed), .rw(rw)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid === 1'b1) begin
        rx_cnt++;
        rxq.push_back(rx_data);
      end
      if (tx_req === 1'b1) tx_cnt++;
      if (scl_oen_n === 1'b0) hold_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop;
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  // One SCL clock: present b, raise SCL (honouring stretching), sample mid-high.
  task automatic bit_xfer(input logic b, output logic s);
    int i;
    m_sda = b; tick(Q);
    m_scl = 1'b1;
    i = 0;
    while (scl_line !== 1'b1 && i < 2000) begin
      tick(1);
      i++;
    end
    if (scl_line !== 1'b1) check("scl_release_timeout", {31'd0, scl_line}, 32'd1);
    tick(Q); s = sda_line;
    tick(Q); m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  // Reads one byte; nxt is presented on tx_data before the ACK clock so the
  // target can load it at the end of that clock.
  task automatic read_byte(input logic mack, input logic [7:0] nxt, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    tx_data = nxt;
    bit_xfer(mack, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         rx0, tx0, n;
    logic [7:0] b;
    rx_ready = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_outs", {scl_oen_n, sda_oen_n, rx_valid, tx_req, busy, addressed, rw},
          7'b1100000);
    check("reset_rx_data", rx_data, 8'h00);

    // 1: plain write
    bus_start;
    check("t1_busy", busy, 1);
    write_byte(8'hA0, ack); check("t1_addr_ack", ack, 0);
    check("t1_addressed", addressed, 1);
    check("t1_rw", rw, 0);
    write_byte(8'h3C, ack); check("t1_data_ack", ack, 0);
    check("t1_rx_cnt", rx_cnt, 1);
    check("t1_rx_data", rx_data, 8'h3C);
    bus_stop; tick(Q);
    check("t1_busy_after_stop", busy, 0);
    check("t1_addr_after_stop", addressed, 0);

    // 2: wrong address, then a retry to the right one
    rx0 = rx_cnt;
    bus_start;
    write_byte(8'hA2, ack); check("t2_nomatch_nack", ack, 1);
    check("t2_not_addressed", addressed, 0);
    check("t2_no_rx", rx_cnt, rx0);
    bus_start;
    write_byte(8'hA0, ack); check("t2_retry_ack", ack, 0);
    bus_stop; tick(Q);

    // 3: two-byte read, ACK then NACK
    tx0 = tx_cnt;
    tx_data = 8'h96;
    bus_start;
    write_byte(8'hA1, ack); check("t3_addr_ack", ack, 0);
    check("t3_rw", rw, 1);
    read_byte(1'b0, 8'h5A, d); check("t3_byte1", d, 8'h96);
    read_byte(1'b1, 8'h00, d); check("t3_byte2", d, 8'h5A);
    check("t3_tx_req_cnt", tx_cnt - tx0, 2);
    check("t3_addressed_after_nack", addressed, 0);
    check("t3_sda_released", sda_oen_n, 1);
    bus_stop; tick(Q);

    // 4: write, repeated START, read
    rx0 = rx_cnt; tx0 = tx_cnt;
    bus_start;
    write_byte(8'hA0, ack); check("t4_waddr_ack", ack, 0);
    write_byte(8'h11, ack); check("t4_wdata_ack", ack, 0);
    check("t4_rw_write", rw, 0);
    tx_data = 8'hC3;
    bus_start;
    check("t4_busy_through_rs", busy, 1);
    write_byte(8'hA1, ack); check("t4_raddr_ack", ack, 0);
    check("t4_rw_read", rw, 1);
    read_byte(1'b1, 8'h00, d); check("t4_rdata", d, 8'hC3);
    check("t4_busy_before_stop", busy, 1);
    check("t4_rx_once", rx_cnt - rx0, 1);
    check("t4_tx_once", tx_cnt - tx0, 1);
    bus_stop; tick(Q);

    // 5: reset while the target drives bit 4 of a read byte (all-zero data)
    tx_data = 8'h00;
    bus_start;
    write_byte(8'hA1, ack); check("t5_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, ack);
    m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q / 2);
    check("t5_driving_before_rst", sda_oen_n, 0);
    rst = 1'b1; tick(1);
    check("t5_rst_outs", {scl_oen_n, sda_oen_n, rx_valid, tx_req, busy, addressed, rw},
          7'b1100000);
    check("t5_rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    tick(Q); m_scl = 1'b0; tick(Q);
    bus_stop; tick(Q);
    b = 8'($urandom);
    bus_start;
    write_byte(8'hA0, ack); check("t5_post_addr_ack", ack, 0);
    write_byte(b, ack); check("t5_post_data_ack", ack, 0);
    check("t5_post_rx_data", rx_data, b);
    bus_stop; tick(Q);

    // 6: hold after a write ACK while rx_ready is low
    rx_ready = 1'b0;
    bus_start;
    write_byte(8'hA0, ack);
    write_byte(8'h55, ack); check("t6_data_ack", ack, 0);
`ifdef SCL_STRETCH_EN
    check("t6_stretch_on", scl_oen_n, 0);
    n = 0;
    repeat (200) begin
      if (scl_oen_n === 1'b0) n++;
      tick(1);
    end
    check("t6_held_cycles", n, 200);
    rx_ready = 1'b1;
    tick(1);
    check("t6_released", scl_oen_n, 1);
`else
    n = 0;
    repeat (200) begin
      if (scl_oen_n === 1'b0) n++;
      tick(1);
    end
    check("t6_no_stretch", n, 0);
    rx_ready = 1'b1;
`endif
    write_byte(8'hE7, ack); check("t6_next_ack", ack, 0);
    check("t6_rx_data", rx_data, 8'hE7);
    bus_stop; tick(Q);
`ifndef SCL_STRETCH_EN
    check("scl_never_held", hold_cnt, 0);
`endif

    // Random transactions against a transaction-level model
    for (int t = 0; t < 6; t++) begin
      logic [6:0] a7;
      logic       rwb, match;
      int         nb;
      logic [7:0] bytes[4];
      a7    = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
      rwb   = 1'($urandom_range(0, 1));
      nb    = $urandom_range(1, 3);
      match = (a7 == 7'h50);
      for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
      rxq.delete();
      rx0 = rx_cnt; tx0 = tx_cnt;
      tx_data = bytes[0];
      bus_start;
      write_byte({a7, rwb}, ack); check("rnd_addr_ack", ack, {31'd0, !match});
      if (match && !rwb) begin
        for (int k = 0; k < nb; k++) begin
          write_byte(bytes[k], ack); check("rnd_wr_ack", ack, 0);
        end
        check("rnd_rx_cnt", rx_cnt - rx0, nb);
        for (int k = 0; k < nb && k < rxq.size(); k++) check("rnd_rx_byte", rxq[k], bytes[k]);
      end else if (match) begin
        for (int k = 0; k < nb; k++) begin
          read_byte(k == nb - 1, bytes[k + 1], d); check("rnd_rd_byte", d, bytes[k]);
        end
        check("rnd_tx_cnt", tx_cnt - tx0, nb);
        check("rnd_rd_done", addressed, 0);
      end else begin
        check("rnd_nomatch_rx", rx_cnt - rx0, 0);
      end
      bus_stop; tick(Q);
      check("rnd_idle", {busy, addressed, sda_oen_n, scl_oen_n}, 4'b0011);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/iic_slave.md
Name: iic_slave

Overview:
- I2C target (responder) that sits on the same open-drain bus as the iic_top master.
- Oversamples SCL/SDA with the system clock and decodes START, STOP and repeated START.
- Matches a 7-bit address, acknowledges it, then either delivers written bytes to the user side or serialises user-supplied bytes onto SDA for master reads.
- Optionally holds SCL low (clock stretching) when the user side is not ready.

Parameters:
SLAVE_ADR, 7'h50, 7-bit bus address this target answers to.
FILT_CYC, 2, number of consecutive clk samples a synchronised SCL/SDA level must hold before it is accepted (glitch filter, 1..7).

Ports:
clk  input  1  system clock; must be at least 16x the SCL rate.
rst  input  1  reset, synchronous, active-high.
scl_i  input  1  SCL pad input.
sda_i  input  1  SDA pad input.
scl_o  output  1  constant 0 (open drain).
scl_oen_n  output  1  active-low output enable for SCL; 0 pulls SCL low.
sda_o  output  1  constant 0 (open drain).
sda_oen_n  output  1  active-low output enable for SDA; 0 pulls SDA low.
rx_data  output  8  last byte written by the master.
rx_valid  output  1  1-cycle pulse; rx_data is new.
rx_ready  input  1  user can accept rx_data (used only with stretching).
tx_data  input  8  byte to return on the next master read.
tx_valid  input  1  tx_data is valid (used only with stretching).
tx_req  output  1  1-cycle pulse requesting the next tx_data.
busy  output  1  high from a detected START until a detected STOP.
addressed  output  1  high from the address ACK until STOP, repeated START or read NACK.
rw  output  1  R/W bit of the current transfer (1 = read), valid while addressed.

Behaviour:
- Reset: state IDLE; scl_oen_n=1, sda_oen_n=1, rx_data=0, rx_valid=0, tx_req=0, busy=0, addressed=0, rw=0, bit counter=0.
- Input path: 2-flop synchroniser, then FILT_CYC filter giving scl_f/sda_f. Edge detect is on the filtered signals.
- START: sda_f falls while scl_f=1. STOP: sda_f rises while scl_f=1.
- Data is sampled on scl_f rising edges. The target changes SDA only in the clk cycle after an scl_f falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first; bit 0 is R/W.
  - ADDR_ACK: on address match, drive sda_oen_n=0 from the falling edge after bit 8 to the falling edge after bit 9. No match -> IDLE, SDA released, wait for the next START. General call is not supported.
  - WR_DATA: shift 8 bits. At the 8th rising edge, load rx_data and pulse rx_valid. Then WR_ACK: always ACK (SDA low for the 9th clock), then return to WR_DATA.
  - RD_DATA: pulse tx_req at the 9th rising edge of the address/previous byte. Latch tx_data at the following falling edge. Drive bit7..bit0: sda_oen_n = the bit value (0 pulls low, 1 releases).
  - RD_ACK: release SDA and sample at the 9th rising edge. ACK(0) -> RD_DATA. NACK(1) -> IDLE, addressed=0.
- START in any state (repeated START) -> ADDR, bit counter cleared, SDA released within 1 clk.
- STOP in any state -> IDLE, busy=0, addressed=0, SDA and SCL released within 1 clk.
- START and STOP are never detected in the same cycle, because each needs an sda_f edge of the opposite direction.
- rst asserted mid-transfer: all outputs take reset values on the next clk edge, and the bus is released.
- Bit counter is 4 bits and counts 0..8. It clears on every START and after every 9th bit.

Optional Feature:
- Macro SCL_STRETCH_EN.
- Defined: after the falling edge that ends a WR_ACK, hold scl_oen_n=0 while rx_ready=0. After the falling edge that precedes RD_DATA bit 7, hold scl_oen_n=0 while tx_valid=0; tx_data is latched on the release cycle. SCL is released 1 clk after the condition is met. STOP, START or rst releases SCL immediately.
- Not defined: scl_oen_n is constantly 1, rx_ready and tx_valid are ignored, and tx_data is latched unconditionally.

Test Plan:
1. START, 0xA0 (0x50 write), 0x3C, STOP -> address ACK; rx_data=0x3C with one rx_valid pulse; data ACK; busy 1->0; addressed cleared at STOP.
2. START, 0xA2 (address 0x51) -> no ACK (SDA stays 1 on the 9th clock), no rx_valid, state returns to IDLE; the next START, 0xA0 is ACKed.
3. START, 0xA1, tx_data=0x96 then 0x5A, master ACKs byte 1 and NACKs byte 2 -> bus carries 0x96 then 0x5A; tx_req pulses twice; addressed drops after the NACK; SDA released.
4. Write 0x11, repeated START, 0xA1, read one byte -> rw goes 0->1; rx_valid once; tx_req once; no STOP detected between.
5. rst high during bit 4 of a read byte -> sda_oen_n=1 and scl_oen_n=1 the next cycle, all outputs at reset values; a following full write transfer succeeds.
6. SCL_STRETCH_EN with rx_ready=0 for 200 clk after byte 0x55 -> SCL held low 200 clk, released 1 clk after rx_ready=1, transfer then completes normally.
